// File: rtl/bp_clint_responder_pkg.sv
// Package: bp_clint_responder_pkg
// Purpose: Shared constants, enums and the offset/size decoder for the CLINT
//          responder. Imported by the interface, the top and the mtime block.
// Contents:
//   clint_data_width_gp   request/response data width (fixed at 64)
//   clint_*_offset_gp     register offsets within the 1 MiB CLINT window
//   bp_clint_size_e       request size encoding
//   bp_clint_state_e      request FSM state (also exposed for debug)
//   bp_clint_sel_e        decoded register target
//   bp_clint_dec_s        decode result (target, half enables, error)
//   clint_decode()        maps offset/size to a decode result
package bp_clint_responder_pkg;

  localparam int unsigned clint_data_width_gp = 64;

  localparam logic [19:0] clint_mipi_offset_gp     = 20'h0_0000;
  localparam logic [19:0] clint_mtimecmp_offset_gp = 20'h0_4000;
  localparam logic [19:0] clint_mtime_offset_gp    = 20'h0_BFF8;

  typedef enum logic [1:0] {
    e_clint_size_1B = 2'b00,
    e_clint_size_2B = 2'b01,
    e_clint_size_4B = 2'b10,
    e_clint_size_8B = 2'b11
  } bp_clint_size_e;

  typedef enum logic {
    e_clint_idle = 1'b0,
    e_clint_resp = 1'b1
  } bp_clint_state_e;

  typedef enum logic [1:0] {
    e_sel_none     = 2'd0,
    e_sel_msip     = 2'd1,
    e_sel_mtimecmp = 2'd2,
    e_sel_mtime    = 2'd3
  } bp_clint_sel_e;

  typedef struct packed {
    bp_clint_sel_e sel;
    logic          lo;   // access touches bits [31:0]
    logic          hi;   // access touches bits [63:32]
    logic          err;  // unmapped offset or illegal size
  } bp_clint_dec_s;

  // 8B accesses are only legal at the base of a 64-bit register; 4B accesses
  // are legal at either half. Everything else is an error with no side effect.
  function automatic bp_clint_dec_s clint_decode(input logic [19:0] off,
                                                 input logic [1:0]  size);
    bp_clint_dec_s d;
    logic          is4;
    logic          is8;
    is4 = (size == e_clint_size_4B);
    is8 = (size == e_clint_size_8B);
    d   = '{sel: e_sel_none, lo: 1'b0, hi: 1'b0, err: 1'b1};
    if ((off == clint_mipi_offset_gp) && is4) begin
      d = '{sel: e_sel_msip, lo: 1'b1, hi: 1'b0, err: 1'b0};
    end else if ((off == clint_mtimecmp_offset_gp) && (is4 || is8)) begin
      d = '{sel: e_sel_mtimecmp, lo: 1'b1, hi: is8, err: 1'b0};
    end else if ((off == clint_mtimecmp_offset_gp + 20'd4) && is4) begin
      d = '{sel: e_sel_mtimecmp, lo: 1'b0, hi: 1'b1, err: 1'b0};
    end else if ((off == clint_mtime_offset_gp) && (is4 || is8)) begin
      d = '{sel: e_sel_mtime, lo: 1'b1, hi: is8, err: 1'b0};
    end else if ((off == clint_mtime_offset_gp + 20'd4) && is4) begin
      d = '{sel: e_sel_mtime, lo: 1'b0, hi: 1'b1, err: 1'b0};
    end
    return d;
  endfunction

endpackage

// File: rtl/bp_clint_responder_if.sv
// Interface: bp_clint_responder_if
// Purpose: Request/response bus between the core-side requester (master) and
//          the CLINT responder (slave).
// Parameters: paddr_width_p - request byte address width
// Signals:
//   req_v_i/req_ready_o   request handshake
//   req_w_i, req_addr_i, req_size_i, req_data_i  request payload
//   resp_v_o/resp_yumi_i  response handshake
//   resp_data_o, resp_err_o                      response payload
//
// Handshake: a request transfers on a cycle where req_v_i & req_ready_o are
// both 1; the payload must be stable while req_v_i is high. A response is
// offered with resp_v_o=1 and its payload stays stable until the cycle where
// resp_yumi_i=1, on which it is consumed. resp_yumi_i may only be raised
// while resp_v_o is 1.
interface bp_clint_responder_if
  import bp_clint_responder_pkg::*;
#(
  parameter int unsigned paddr_width_p = 56
);
  logic                           req_v_i;
  logic                           req_ready_o;
  logic                           req_w_i;
  logic [paddr_width_p-1:0]       req_addr_i;
  logic [1:0]                     req_size_i;
  logic [clint_data_width_gp-1:0] req_data_i;
  logic                           resp_v_o;
  logic                           resp_yumi_i;
  logic [clint_data_width_gp-1:0] resp_data_o;
  logic                           resp_err_o;

  modport master (
    output req_v_i, req_w_i, req_addr_i, req_size_i, req_data_i, resp_yumi_i,
    input  req_ready_o, resp_v_o, resp_data_o, resp_err_o
  );

  modport slave (
    input  req_v_i, req_w_i, req_addr_i, req_size_i, req_data_i, resp_yumi_i,
    output req_ready_o, resp_v_o, resp_data_o, resp_err_o
  );
endinterface

// File: rtl/bp_clint_responder_mtime.sv
// Module: bp_clint_mtime
// Purpose: Free-running 64-bit mtime counter with half-word write port,
//          optional prescaler and registered mtime >= mtimecmp compare.
// Build option: BP_CLINT_PRESCALER_EN - when defined, mtime advances once per
//          mtime_div_p cycles; otherwise every cycle.
// Ports:
//   clk_i, reset_n_i   clock, async active-low reset
//   i_wr_lo, i_wr_hi   write enables for mtime[31:0] / mtime[63:32]
//   i_wdata            write data, already aligned to the 64-bit register
//   i_mtimecmp         current compare value
//   o_mtime            current mtime (value before this cycle's increment)
//   o_timer_irq        registered (mtime >= mtimecmp)
//   o_presc_cnt        prescale counter (constant 0 without the prescaler)
module bp_clint_mtime #(
  parameter  int unsigned mtime_div_p = 8,
  localparam int unsigned presc_w_lp  = (mtime_div_p > 2) ? $clog2(mtime_div_p) : 1
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  input  logic                  i_wr_lo,
  input  logic                  i_wr_hi,
  input  logic [63:0]           i_wdata,
  input  logic [63:0]           i_mtimecmp,
  output logic [63:0]           o_mtime,
  output logic                  o_timer_irq,
  output logic [presc_w_lp-1:0] o_presc_cnt
);
  logic        w_tick;
  logic        w_wr;
  logic [63:0] r_mtime;
  logic [63:0] w_mtime_next;
  logic        r_timer_irq;

  assign w_wr = i_wr_lo | i_wr_hi;

`ifdef BP_CLINT_PRESCALER_EN
  localparam logic [presc_w_lp-1:0] presc_max_lp = presc_w_lp'(mtime_div_p - 1);
  logic [presc_w_lp-1:0] r_presc;

  assign w_tick = (r_presc == presc_max_lp);

  // A write to mtime restarts the prescale period so the written value holds
  // for a full period.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)  r_presc <= '0;
    else if (w_wr)   r_presc <= '0;
    else if (w_tick) r_presc <= '0;
    else             r_presc <= r_presc + 1'b1;
  end

  assign o_presc_cnt = r_presc;
`else
  assign w_tick      = 1'b1;
  assign o_presc_cnt = '0;
`endif

  // A write replaces the increment for that cycle; the unwritten half keeps
  // its pre-increment value.
  always_comb begin
    w_mtime_next = r_mtime + {63'b0, w_tick};
    if (w_wr) begin
      w_mtime_next = r_mtime;
      if (i_wr_lo) w_mtime_next[31:0]  = i_wdata[31:0];
      if (i_wr_hi) w_mtime_next[63:32] = i_wdata[63:32];
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_mtime     <= '0;
      r_timer_irq <= 1'b0;
    end else begin
      r_mtime     <= w_mtime_next;
      r_timer_irq <= (r_mtime >= i_mtimecmp);
    end
  end

  assign o_mtime     = r_mtime;
  assign o_timer_irq = r_timer_irq;
endmodule

// File: rtl/bp_clint_responder.sv
// Module: bp_clint_responder
// Purpose: Memory-mapped CLINT target. Holds msip (+0x0000), mtimecmp
//          (+0x4000) and mtime (+0xBFF8, in bp_clint_mtime) and drives the
//          software/timer interrupts to the core. One request outstanding.
// Build option: BP_CLINT_PRESCALER_EN - enables the mtime prescaler.
// Ports:
//   clk_i, reset_n_i  clock, async active-low reset
//   bus               request/response bus (slave side)
//   software_irq_o    msip[0]
//   timer_irq_o       registered (mtime >= mtimecmp)
//   dbg_state_o       request FSM state
//   dbg_presc_cnt_o   mtime prescale counter (0 without the prescaler)
module bp_clint_responder
  import bp_clint_responder_pkg::*;
#(
  parameter  int unsigned mtime_div_p = 8,
  localparam int unsigned presc_w_lp  = (mtime_div_p > 2) ? $clog2(mtime_div_p) : 1
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  bp_clint_responder_if.slave   bus,
  output logic                  software_irq_o,
  output logic                  timer_irq_o,
  output bp_clint_state_e       dbg_state_o,
  output logic [presc_w_lp-1:0] dbg_presc_cnt_o
);
  bp_clint_state_e r_state, w_state_next;
  bp_clint_dec_s   w_dec;
  logic            w_accept;
  logic            w_wr;
  logic [63:0]     w_wdata;
  logic [63:0]     w_mtime;
  logic [63:0]     w_rsel;
  logic [63:0]     w_rdata;
  logic [63:0]     r_mtimecmp;
  logic            r_msip;
  logic [63:0]     r_resp_data;
  logic            r_resp_err;
  logic            w_unused_addr;

  // Routing to this device is resolved upstream; only the offset matters here.
  assign w_unused_addr = ^(bus.req_addr_i >> 20);

  assign w_accept = bus.req_v_i & bus.req_ready_o;
  assign w_dec    = clint_decode(bus.req_addr_i[19:0], bus.req_size_i);
  assign w_wr     = w_accept & bus.req_w_i & ~w_dec.err;

  // 4B writes carry their data in [31:0] whichever half they target, so the
  // low word is mirrored into both halves and the half enables pick one.
  assign w_wdata = (w_dec.lo & w_dec.hi) ? bus.req_data_i
                                         : {bus.req_data_i[31:0], bus.req_data_i[31:0]};

  // Request FSM
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) r_state <= e_clint_idle;
    else            r_state <= w_state_next;
  end

  always_comb begin
    w_state_next    = r_state;
    bus.req_ready_o = 1'b0;
    bus.resp_v_o    = 1'b0;
    case (r_state)
      e_clint_idle: begin
        bus.req_ready_o = 1'b1;
        if (bus.req_v_i) w_state_next = e_clint_resp;
      end
      e_clint_resp: begin
        bus.resp_v_o = 1'b1;
        if (bus.resp_yumi_i) w_state_next = e_clint_idle;
      end
      default: w_state_next = e_clint_idle;
    endcase
  end

  // Read data: writes and errors respond with 0; 4B reads are zero-extended.
  always_comb begin
    w_rsel = '0;
    case (w_dec.sel)
      e_sel_msip:     w_rsel = {63'b0, r_msip};
      e_sel_mtimecmp: w_rsel = r_mtimecmp;
      e_sel_mtime:    w_rsel = w_mtime;
      default:        w_rsel = '0;
    endcase
    w_rdata = '0;
    if (!w_dec.err && !bus.req_w_i) begin
      if (w_dec.lo && w_dec.hi) w_rdata = w_rsel;
      else if (w_dec.lo)        w_rdata = {32'b0, w_rsel[31:0]};
      else if (w_dec.hi)        w_rdata = {32'b0, w_rsel[63:32]};
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_msip      <= 1'b0;
      r_mtimecmp  <= '1;
      r_resp_data <= '0;
      r_resp_err  <= 1'b0;
    end else begin
      if (w_wr && (w_dec.sel == e_sel_msip)) r_msip <= w_wdata[0];
      if (w_wr && (w_dec.sel == e_sel_mtimecmp)) begin
        if (w_dec.lo) r_mtimecmp[31:0]  <= w_wdata[31:0];
        if (w_dec.hi) r_mtimecmp[63:32] <= w_wdata[63:32];
      end
      if (w_accept) begin
        r_resp_data <= w_rdata;
        r_resp_err  <= w_dec.err;
      end
    end
  end

  bp_clint_mtime #(.mtime_div_p(mtime_div_p)) u_mtime (
    .clk_i       (clk_i),
    .reset_n_i   (reset_n_i),
    .i_wr_lo     (w_wr && (w_dec.sel == e_sel_mtime) && w_dec.lo),
    .i_wr_hi     (w_wr && (w_dec.sel == e_sel_mtime) && w_dec.hi),
    .i_wdata     (w_wdata),
    .i_mtimecmp  (r_mtimecmp),
    .o_mtime     (w_mtime),
    .o_timer_irq (timer_irq_o),
    .o_presc_cnt (dbg_presc_cnt_o)
  );

  assign bus.resp_data_o = r_resp_data;
  assign bus.resp_err_o  = r_resp_err;
  assign software_irq_o  = r_msip;
  assign dbg_state_o     = r_state;
endmodule
